// File: rtl/tank2urex7_sprite_fetch.sv
// tank2urex7_sprite_fetch
// Per-pixel sprite fetch in front of tank2urex7_palette. It turns the scan
// position into a rotated address for the synchronous sprite ROM. It aligns
// the hit flag with the ROM read latency, then emits a palette index and an
// opaque flag. Tank position, facing and enable are shadow-latched on
// frame_start, so a move in the middle of a frame never tears the sprite.
module tank2urex7_sprite_fetch #(
    parameter int SPR_W   = 32,  // sprite width, must equal SPR_H
    parameter int SPR_H   = 32,  // sprite height
    parameter int ADDR_W  = 10,  // ROM address width, 2**ADDR_W >= SPR_W*SPR_H
    parameter int ROM_LAT = 1,   // ROM read latency in cycles (1 or 2)
    parameter int TRANSP  = 0    // transparent palette index
) (
    input  logic              Clk,
    input  logic              Reset_n,
    input  logic              frame_start,
    input  logic [9:0]        DrawX,
    input  logic [9:0]        DrawY,
    input  logic              blank,
    input  logic [9:0]        tank_x,
    input  logic [9:0]        tank_y,
    input  logic [1:0]        tank_dir,
    input  logic              tank_en,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [3:0]        rom_q,
    output logic [3:0]        pix_index,
    output logic              pix_opaque
);

    localparam logic [10:0] SPR_W_11   = 11'(SPR_W);
    localparam logic [10:0] SPR_H_11   = 11'(SPR_H);
    localparam logic [10:0] W_M1_11    = 11'(SPR_W - 1);
    localparam logic [3:0]  TRANSP_IDX = 4'(TRANSP);

    // Frame-stable copy of the tank state
    logic [9:0] sx;
    logic [9:0] sy;
    logic [1:0] sdir;
    logic       sen;

    // Stage 0 (combinational) signals
    logic [10:0]       rx_p0;
    logic [10:0]       ry_p0;
    logic [10:0]       u_p0;
    logic [10:0]       v_p0;
    logic              hit_p0;
    logic [ADDR_W-1:0] addr_p0;

    // Hit flag after the address register, then delayed across the ROM
    logic               vld_p1;
    logic [ROM_LAT-1:0] vld_p2;
    logic               dhit;

    // Shadow-latch tank state once per frame; the pixel in the latch cycle sees the old values
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            sx   <= '0;
            sy   <= '0;
            sdir <= '0;
            sen  <= 1'b0;
        end else if (frame_start) begin
            sx   <= tank_x;
            sy   <= tank_y;
            sdir <= tank_dir;
            sen  <= tank_en;
        end
    end

    // ---- stage 0: sprite-relative offset, hit test, rotation, address ----
    // Offsets are 11-bit unsigned, so a pixel left of or above the sprite wraps large and misses
    always_comb begin
        rx_p0  = {1'b0, DrawX} - {1'b0, sx};
        ry_p0  = {1'b0, DrawY} - {1'b0, sy};
        hit_p0 = blank & sen & (rx_p0 < SPR_W_11) & (ry_p0 < SPR_H_11);
        u_p0   = rx_p0;
        v_p0   = ry_p0;
        case (sdir)
            2'd0: begin
                u_p0 = rx_p0;
                v_p0 = ry_p0;
            end
            2'd1: begin
                u_p0 = ry_p0;
                v_p0 = W_M1_11 - rx_p0;
            end
            2'd2: begin
                u_p0 = W_M1_11 - rx_p0;
                v_p0 = W_M1_11 - ry_p0;
            end
            default: begin
                u_p0 = W_M1_11 - ry_p0;
                v_p0 = rx_p0;
            end
        endcase
        addr_p0 = ADDR_W'(v_p0) * ADDR_W'(SPR_W) + ADDR_W'(u_p0);
    end

    // ---- stage 1: register address and hit; address holds on a miss to keep the ROM quiet ----
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            rom_addr <= '0;
            vld_p1   <= 1'b0;
        end else begin
            vld_p1 <= hit_p0;
            if (hit_p0) begin
                rom_addr <= addr_p0;
            end
        end
    end

    // ---- stage 2: delay the hit flag by the ROM read latency ----
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            vld_p2 <= '0;
        end else begin
            vld_p2 <= ROM_LAT'({vld_p2, vld_p1});
        end
    end

    assign dhit = vld_p2[ROM_LAT-1];

    // ROM data is used straight from the ROM output register, with no extra stage
    assign pix_index  = dhit ? rom_q : TRANSP_IDX;
    assign pix_opaque = dhit & (rom_q != TRANSP_IDX);

endmodule

// File: tb/tb_tank2urex7_sprite_fetch.sv
// Testbench for tank2urex7_sprite_fetch: directed scenarios plus random scan
// traffic, all checked against a behavioural per-pixel model with a 1-cycle ROM.
module tb_tank2urex7_sprite_fetch;

    logic       Clk = 1'b0;
    logic       Reset_n = 1'b0;
    logic       frame_start = 1'b0;
    logic [9:0] DrawX = '0;
    logic [9:0] DrawY = '0;
    logic       blank = 1'b0;
    logic [9:0] tank_x = '0;
    logic [9:0] tank_y = '0;
    logic [1:0] tank_dir = '0;
    logic       tank_en = 1'b0;
    logic [9:0] rom_addr;
    logic [3:0] rom_q;
    logic [3:0] pix_index;
    logic       pix_opaque;

    logic [3:0] rom [0:1023];

    int n_chk  = 0;
    int n_pass = 0;

    // model state: frame shadow and the pixel waiting on the ROM
    int msx = 0, msy = 0, mdir = 0;
    bit men = 0;
    bit mhit1 = 0;
    int maddr1 = 0;

    tank2urex7_sprite_fetch #(
        .SPR_W(32), .SPR_H(32), .ADDR_W(10), .ROM_LAT(1), .TRANSP(0)
    ) dut (
        .Clk(Clk), .Reset_n(Reset_n), .frame_start(frame_start),
        .DrawX(DrawX), .DrawY(DrawY), .blank(blank),
        .tank_x(tank_x), .tank_y(tank_y), .tank_dir(tank_dir), .tank_en(tank_en),
        .rom_addr(rom_addr), .rom_q(rom_q),
        .pix_index(pix_index), .pix_opaque(pix_opaque)
    );

    always #5 Clk = ~Clk;

    // synchronous sprite ROM, 1 cycle latency
    always @(posedge Clk) rom_q <= rom[rom_addr];

    task automatic check(input string tag, input int got, input int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    // Screen-space model: is the pixel on the sprite, and which texel does it show
    function automatic void ref_pix(output bit h, output int a);
        int rx, ry, u, v;
        rx = int'(DrawX) - msx;
        ry = int'(DrawY) - msy;
        h = (blank == 1'b1) && men && rx >= 0 && rx < 32 && ry >= 0 && ry < 32;
        case (mdir)
            0:       begin u = rx;      v = ry;      end
            1:       begin u = ry;      v = 31 - rx; end
            2:       begin u = 31 - rx; v = 31 - ry; end
            default: begin u = 31 - ry; v = rx;      end
        endcase
        a = ((v * 32 + u) % 1024 + 1024) % 1024;
    endfunction

    // one clock: advance the model with the presented pixel and compare all outputs
    task automatic step();
        bit hp, h;
        int ap, a, ei;
        @(posedge Clk);
        hp = mhit1;
        ap = maddr1;
        ref_pix(h, a);
        mhit1 = h;
        if (h) maddr1 = a;
        if (frame_start) begin
            msx = int'(tank_x); msy = int'(tank_y); mdir = int'(tank_dir); men = tank_en;
        end
        #1;
        ei = hp ? int'(rom[ap]) : 0;
        check("addr", int'(rom_addr), maddr1);
        check("idx", int'(pix_index), ei);
        check("opq", int'(pix_opaque), (hp && rom[ap] != 4'd0) ? 1 : 0);
    endtask

    task automatic pix(input int x, input int y, input bit b);
        DrawX = 10'(x);
        DrawY = 10'(y);
        blank = b;
        step();
    endtask

    task automatic latch(input int x, input int y, input int d, input bit en);
        tank_x = 10'(x); tank_y = 10'(y); tank_dir = 2'(d); tank_en = en;
        frame_start = 1'b1;
        pix(0, 0, 1'b0);
        frame_start = 1'b0;
    endtask

    task automatic do_reset();
        #2;
        Reset_n = 1'b0;
        #1;
        check("rst_idx", int'(pix_index), 0);
        check("rst_opq", int'(pix_opaque), 0);
        check("rst_addr", int'(rom_addr), 0);
        mhit1 = 0; maddr1 = 0; msx = 0; msy = 0; mdir = 0; men = 0;
        @(posedge Clk);
        @(posedge Clk);
        @(negedge Clk);
        Reset_n = 1'b1;
    endtask

    int t3_addr [3] = '{834, 954, 189};

    initial begin
        for (int i = 0; i < 1024; i++) rom[i] = 4'($urandom_range(0, 15));
        rom[0]   = 4'd4;
        rom[69]  = 4'd9;
        rom[70]  = 4'd11;
        rom[189] = 4'd12;
        rom[307] = 4'd6;
        rom[330] = 4'd0;
        rom[834] = 4'd3;
        rom[954] = 4'd7;

        // reset state
        #1;
        check("init_idx", int'(pix_index), 0);
        check("init_opq", int'(pix_opaque), 0);
        check("init_addr", int'(rom_addr), 0);
        @(posedge Clk);
        @(negedge Clk);
        Reset_n = 1'b1;

        // dir0 hit
        latch(100, 50, 0, 1'b1);
        pix(105, 52, 1'b1);
        check("t2_addr", int'(rom_addr), 69);
        pix(0, 0, 1'b1);
        check("t2_idx", int'(pix_index), 9);
        check("t2_opq", int'(pix_opaque), 1);

        // reset with hits in flight
        pix(105, 52, 1'b1);
        pix(106, 52, 1'b1);
        check("t1_pre_opq", int'(pix_opaque), 1);
        do_reset();
        for (int i = 0; i < 4; i++) begin
            pix(105 + i, 52, 1'b1);
            check("t1_post_opq", int'(pix_opaque), 0);
        end

        // rotations
        for (int d = 1; d < 4; d++) begin
            latch(100, 50, d, 1'b1);
            pix(105, 52, 1'b1);
            check($sformatf("t3_addr_dir%0d", d), int'(rom_addr), t3_addr[d-1]);
            pix(0, 0, 1'b0);
        end

        // edges and clipping
        latch(620, 470, 0, 1'b1);
        pix(639, 479, 1'b1);
        check("t4_corner_addr", int'(rom_addr), 307);
        pix(619, 479, 1'b1);
        check("t4_corner_opq", int'(pix_opaque), 1);
        pix(0, 0, 1'b0);
        check("t4_left_miss_opq", int'(pix_opaque), 0);
        latch(0, 0, 0, 1'b1);
        pix(0, 0, 1'b1);
        check("t4_x0_addr", int'(rom_addr), 0);
        pix(0, 0, 1'b0);
        check("t4_x0_opq", int'(pix_opaque), 1);

        // frame latch
        latch(100, 50, 0, 1'b1);
        tank_x = 10'd200;
        pix(105, 52, 1'b1);
        check("t5_live_ignored", int'(rom_addr), 69);
        frame_start = 1'b1;
        pix(106, 52, 1'b1);
        frame_start = 1'b0;
        check("t5_fs_cycle_old", int'(rom_addr), 70);
        pix(106, 52, 1'b1);
        check("t5_fs_cycle_opq", int'(pix_opaque), 1);
        pix(205, 52, 1'b1);
        check("t5_old_pos_miss", int'(pix_opaque), 0);
        check("t5_new_pos_addr", int'(rom_addr), 69);

        // transparency and blank
        latch(100, 50, 0, 1'b1);
        pix(110, 60, 1'b1);
        pix(0, 0, 1'b0);
        check("t6_transp_idx", int'(pix_index), 0);
        check("t6_transp_opq", int'(pix_opaque), 0);
        for (int x = 100; x < 132; x++) begin
            pix(x, 60, 1'b0);
            check("t6_blank_opq", int'(pix_opaque), 0);
        end

        // random scan traffic
        for (int i = 0; i < 3000; i++) begin
            int tx;
            if ($urandom_range(0, 99) == 0) begin
                tank_x = 10'($urandom_range(0, 639));
                tank_y = 10'($urandom_range(0, 479));
                tank_dir = 2'($urandom_range(0, 3));
                tank_en = ($urandom_range(0, 7) != 0);
                frame_start = 1'b1;
            end else if ($urandom_range(0, 49) == 0) begin
                tank_x = 10'($urandom_range(0, 639));
            end
            tx = msx + $urandom_range(0, 44) - 6;
            if (tx < 0) tx = 0;
            pix(tx, msy + $urandom_range(0, 40) - 4, ($urandom_range(0, 9) != 0));
            frame_start = 1'b0;
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
